// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor; state values come from
// serial_sub_defs.vh so the encoding lives in one place.
package serial_subtractor_pkg;

`include "serial_sub_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE  = `SS_ST_IDLE,
        ST_SHIFT = `SS_ST_SHIFT,
        ST_DONE  = `SS_ST_DONE
    } state_t;

endpackage

// File: rtl/serial_sub_defs.vh
// State encodings for serial_subtractor, shared by the package and any
// debug tooling that needs to decode the raw state register.
`ifndef SERIAL_SUB_DEFS_VH
`define SERIAL_SUB_DEFS_VH

`define SS_ST_IDLE  2'd0
`define SS_ST_SHIFT 2'd1
`define SS_ST_DONE  2'd2

`endif

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell (x - y - bin) built from gate primitives;
// the serial subtractor reuses one instance for every bit slice.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_xor_y;
    logic x_n;
    logic xy_n;
    logic brw_gen;
    logic brw_prop;

    xor g_xy   (x_xor_y, x, y);
    xor g_d    (d, x_xor_y, bin);
    not g_xn   (x_n, x);
    and g_gen  (brw_gen, x_n, y);
    not g_xyn  (xy_n, x_xor_y);
    and g_prop (brw_prop, xy_n, bin);
    or  g_bout (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | one bit slice per clock through the full-subtractor cell
// DONE  | result held on diff/bout until out_ready is sampled
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             cell_d;
    logic             cell_bout;
    logic             last_slice;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_slice = (count_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        count_q  <= '0;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    diff_q   <= {cell_d, diff_q[WIDTH-1:1]};
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    borrow_q <= cell_bout;
                    count_q  <= count_q + CNT_W'(1);
                    if (last_slice) begin
                        state_q <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into the MSB slice differs from borrow out.
                        ovf_q   <= borrow_q ^ cell_bout;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so it stays low while reset is held.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign diff      = diff_q;
    assign bout      = out_valid & borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = out_valid & ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: behavioural arithmetic model,
// per-cycle compare process, directed vectors and randomized operations.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int FULL  = 1 << WIDTH;
    localparam int HALF  = 1 << (WIDTH - 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_checks;
    int n_errors;

    logic [WIDTH+1:0] exp_q[$];
    logic             in_flight;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input int av, input int bv, input int bi);
        int raw;
        int sa;
        int sb;
        int sr;
        logic [WIDTH-1:0] d;
        logic bo;
        logic ov;
        raw = av - bv - bi;
        d   = WIDTH'((raw + 2 * FULL) % FULL);
        bo  = (raw < 0);
        sa  = (av >= HALF) ? av - FULL : av;
        sb  = (bv >= HALF) ? bv - FULL : bv;
        sr  = sa - sb - bi;
        ov  = (sr < -HALF) || (sr > HALF - 1);
        return {ov, bo, d};
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(a), int'(b), int'(bin)));
                in_flight = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_flight = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(in_flight));
            chk("in_ready", 32'(in_ready), 32'(!in_flight));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("diff", 32'(diff), 32'(exp_q[0][WIDTH-1:0]));
                    chk("bout", 32'(bout), 32'(exp_q[0][WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
                    chk("ovf", 32'(ovf), 32'(exp_q[0][WIDTH+1]));
`endif
                end
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic bi, input int hold, input bit pulse,
                          output logic [WIDTH-1:0] got_diff, output logic got_bout,
                          output logic got_ovf);
        int k;
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
            if (pulse && k == 3) begin
                a = ~av; b = ~bv; bin = ~bi; in_valid = 1'b1;
            end
            if (pulse && k == 4) in_valid = 1'b0;
        end
        chk("latency", 32'(k), 32'(WIDTH));
        got_diff = diff;
        got_bout = bout;
`ifdef SERIAL_SUB_OVF_EN
        got_ovf = ovf;
`else
        got_ovf = 1'b0;
`endif
        if (pulse) begin
            a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        chk("held_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("ret_idle_in_ready", 32'(in_ready), 32'd1);
        chk("ret_idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    logic [WIDTH-1:0] gd;
    logic             gb;
    logic             go;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t dir_vecs[4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        in_flight = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        dir_vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        dir_vecs[1] = '{8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0};
        dir_vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        dir_vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        foreach (dir_vecs[i])
            chk($sformatf("model_pin_%0d", i),
                32'(model(int'(dir_vecs[i].a), int'(dir_vecs[i].b), int'(dir_vecs[i].bi))),
                32'({dir_vecs[i].ov, dir_vecs[i].bo, dir_vecs[i].d}));

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        foreach (dir_vecs[i]) begin
            run_op(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].bi, 0, 1'b0, gd, gb, go);
            chk($sformatf("dir_diff_%0d", i), 32'(gd), 32'(dir_vecs[i].d));
            chk($sformatf("dir_bout_%0d", i), 32'(gb), 32'(dir_vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("dir_ovf_%0d", i), 32'(go), 32'(dir_vecs[i].ov));
`endif
        end

        // Backpressure in DONE with stray in_valid pulses in SHIFT and DONE.
        run_op(8'h37, 8'h12, 1'b0, 5, 1'b1, gd, gb, go);
        chk("hold_diff", 32'(gd), 32'h25);
        chk("hold_bout", 32'(gb), 32'd0);
        chk("hold_no_stray_accept", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset at count=3 in SHIFT.
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        exp_q.delete();
        in_flight = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h50, 8'h20, 1'b0, 1, 1'b0, gd, gb, go);
        chk("post_rst_diff", 32'(gd), 32'h30);
        chk("post_rst_bout", 32'(gb), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom_range(0, FULL - 1));
            rb = WIDTH'($urandom_range(0, FULL - 1));
            if (i == 0) begin ra = '1; rb = '0; end
            if (i == 1) begin ra = '0; rb = '1; end
            if (i == 2) begin ra = '1; rb = '1; end
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, gd, gb, go);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
